// File: rtl/mem_sched_pkg.sv
`default_nettype none
// ============================================================================
// mem_sched_pkg
// Shared address-map defaults, bus op encodings, scheduler state encodings
// and the address decoder used by the memory scheduler and its UART sequencer.
// Revision: 1.0
// ============================================================================
package mem_sched_pkg;

    localparam logic [17:0] RAM2_TOP_DEF  = 18'h07FFF;
    localparam logic [17:0] UART_DATA_DEF = 18'h0BF00;
    localparam logic [17:0] UART_STAT_DEF = 18'h0BF01;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        S_RD   = 4'd1,
        S_WR1  = 4'd2,
        S_WR2  = 4'd3,
        U_RDW  = 4'd4,
        U_RD   = 4'd5,
        U_WR1  = 4'd6,
        U_WR2  = 4'd7,
        U_WAIT = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        T_SRAM2 = 2'd0,
        T_SRAM1 = 2'd1,
        T_UART  = 2'd2,
        T_STAT  = 2'd3
    } target_t;

    // SRAM2 owns the low range; the two UART registers are exact matches;
    // everything else falls through to SRAM1.
    function automatic target_t decode_target(
        input logic [17:0] addr,
        input logic [17:0] ram2_top,
        input logic [17:0] uart_data,
        input logic [17:0] uart_stat
    );
        if (addr <= ram2_top)       return T_SRAM2;
        else if (addr == uart_data) return T_UART;
        else if (addr == uart_stat) return T_STAT;
        else                        return T_SRAM1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_sched_uart_seq.sv
`default_nettype none
// ============================================================================
// uart_seq
// UART strobe sequencer: read waits for data_ready then pulses rdn; write
// pulses wrn then waits for the transmitter to drain. Returns a one-cycle
// done pulse and, for reads, the captured byte.
// Revision: 1.0
// ============================================================================
module uart_seq
    import mem_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start_rd,
    input  logic       start_wr,
    input  logic [7:0] bus_byte,
    input  logic       data_ready,
    input  logic       tx_idle,
    output logic       rdn,
    output logic       wrn,
    output logic       drive,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_byte
);

    state_t state_q;
    state_t state_d;

    // State register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state: handshake progression for read and write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_rd)      state_d = U_RDW;
                     else if (start_wr) state_d = U_WR1;
            U_RDW:   if (data_ready)    state_d = U_RD;
            U_RD:                       state_d = IDLE;
            U_WR1:                      state_d = U_WR2;
            U_WR2:                      state_d = U_WAIT;
            U_WAIT:  if (tx_idle)       state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Outputs: strobes are low only in their single strobe state.
    always_comb begin
        rdn   = (state_q != U_RD);
        wrn   = (state_q != U_WR1);
        drive = (state_q == U_WR1) || (state_q == U_WR2);
        busy  = (state_q != IDLE);
    end

    // Completion pulse and read byte capture at the end of the handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done    <= 1'b0;
            rx_byte <= 8'h00;
        end else begin
            done <= (state_q == U_RD) || ((state_q == U_WAIT) && tx_idle);
            if (state_q == U_RD) rx_byte <= bus_byte;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_sched.sv
`default_nettype none
// ============================================================================
// mem_sched
// Single-transaction scheduler arbitrating a fetch port and a data port onto
// two asynchronous SRAMs and a UART (sharing the SRAM1 data bus).
// Revision: 1.0
// ============================================================================
module mem_sched
    import mem_sched_pkg::*;
#(
    parameter logic [17:0] RAM2_TOP  = RAM2_TOP_DEF,
    parameter logic [17:0] UART_DATA = UART_DATA_DEF,
    parameter logic [17:0] UART_STAT = UART_STAT_DEF
) (
    input  logic        clk_50MHz,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_pc,
    output logic [15:0] if_inst,
    output logic        if_valid,
    input  logic        mem_req,
    input  logic        mem_op,
    input  logic [17:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_done,
    output logic        stall,
    output logic [17:0] s2_addr,
    output logic [15:0] s2_wdata,
    input  logic [15:0] s2_rdata,
    output logic        s2_drive,
    output logic        s2_ce_n,
    output logic        s2_oe_n,
    output logic        s2_we_n,
    output logic [17:0] r1_addr,
    output logic [15:0] r1_wdata,
    input  logic [15:0] r1_rdata,
    output logic        r1_drive,
    output logic        r1_ce_n,
    output logic        r1_oe_n,
    output logic        r1_we_n,
    output logic        rdn,
    output logic        wrn,
    input  logic        data_ready,
    input  logic        tbre,
    input  logic        tsre
);

    state_t      state_q, state_d;
    target_t     tgt_q, mem_tgt;
    logic [17:0] addr_q;
    logic [15:0] wdata_q, rdata_q;
    logic        op_q, fetch_q, last_mem_q, valid_q, done_q;
    logic        mem_pend, if_pend, can_grant, grant_if, grant_mem;
    logic        u_start_rd, u_start_wr, u_rdn, u_wrn, u_drive, u_busy, u_done;
    logic [7:0]  u_byte;
    logic        sel_s2, sel_s1, in_rd, in_wr1, in_wr;

    assign mem_tgt = decode_target(mem_addr, RAM2_TOP, UART_DATA, UART_STAT);

    // Arbitration: a port whose ack is showing this cycle is not re-granted.
    always_comb begin
        mem_pend  = mem_req && !mem_done;
        if_pend   = if_req && !valid_q;
        can_grant = (state_q == IDLE) && !u_busy;
        grant_if  = can_grant && if_pend && (!mem_pend || last_mem_q);
        grant_mem = can_grant && mem_pend && !grant_if;
        u_start_rd = grant_mem && (mem_tgt == T_UART) && (mem_op == OP_RD);
        u_start_wr = grant_mem && (mem_tgt == T_UART) && (mem_op == OP_WR);
    end

    // State register, cleared asynchronously.
    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state for SRAM cycles; UART and status grants leave this FSM idle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_if)
                    state_d = S_RD;
                else if (grant_mem && (mem_tgt == T_SRAM2 || mem_tgt == T_SRAM1))
                    state_d = (mem_op == OP_WR) ? S_WR1 : S_RD;
            end
            S_RD:    state_d = IDLE;
            S_WR1:   state_d = S_WR2;
            S_WR2:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: SRAM strobes decoded from state and latched target.
    always_comb begin
        in_rd    = (state_q == S_RD);
        in_wr1   = (state_q == S_WR1);
        in_wr    = in_wr1 || (state_q == S_WR2);
        sel_s2   = (in_rd || in_wr) && (tgt_q == T_SRAM2);
        sel_s1   = (in_rd || in_wr) && (tgt_q == T_SRAM1);
        s2_ce_n  = !sel_s2;
        s2_oe_n  = !(sel_s2 && in_rd);
        s2_we_n  = !(sel_s2 && in_wr1);
        s2_drive = sel_s2 && in_wr;
        s2_addr  = sel_s2 ? addr_q : 18'h0;
        s2_wdata = s2_drive ? wdata_q : 16'h0;
        r1_ce_n  = !sel_s1;
        r1_oe_n  = !(sel_s1 && in_rd);
        r1_we_n  = !(sel_s1 && in_wr1);
        r1_drive = (sel_s1 && in_wr) || u_drive;
        r1_addr  = sel_s1 ? addr_q : 18'h0;
        r1_wdata = r1_drive ? wdata_q : 16'h0;
        rdn      = u_rdn;
        wrn      = u_wrn;
    end

    // Grant latching, read capture and one-cycle acknowledge pulses.
    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            tgt_q      <= T_SRAM2;
            addr_q     <= 18'h0;
            wdata_q    <= 16'h0;
            rdata_q    <= 16'h0;
            op_q       <= OP_RD;
            fetch_q    <= 1'b0;
            last_mem_q <= 1'b1;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (grant_if) begin
                addr_q     <= {2'b00, if_pc};
                tgt_q      <= T_SRAM2;
                op_q       <= OP_RD;
                fetch_q    <= 1'b1;
                last_mem_q <= 1'b0;
            end else if (grant_mem) begin
                addr_q     <= mem_addr;
                wdata_q    <= mem_wdata;
                tgt_q      <= mem_tgt;
                op_q       <= mem_op;
                fetch_q    <= 1'b0;
                last_mem_q <= 1'b1;
                // Status register answers immediately; writes to it are dropped.
                if (mem_tgt == T_STAT) begin
                    done_q <= 1'b1;
                    if (mem_op == OP_RD) rdata_q <= {14'b0, data_ready, tbre & tsre};
                end
            end
            if (state_q == S_RD) begin
                rdata_q <= (tgt_q == T_SRAM1) ? r1_rdata : s2_rdata;
                if (fetch_q) valid_q <= 1'b1;
                else         done_q  <= 1'b1;
            end
            if (state_q == S_WR2) done_q <= 1'b1;
            if (u_done && op_q == OP_RD) rdata_q <= {8'h00, u_byte};
        end
    end

    uart_seq u_uart_seq (
        .clk        (clk_50MHz),
        .rst        (rst),
        .start_rd   (u_start_rd),
        .start_wr   (u_start_wr),
        .bus_byte   (r1_rdata[7:0]),
        .data_ready (data_ready),
        .tx_idle    (tbre & tsre),
        .rdn        (u_rdn),
        .wrn        (u_wrn),
        .drive      (u_drive),
        .busy       (u_busy),
        .done       (u_done),
        .rx_byte    (u_byte)
    );

    assign if_inst   = rdata_q;
    assign if_valid  = valid_q;
    assign mem_done  = done_q || u_done;
    assign mem_rdata = (u_done && op_q == OP_RD) ? {8'h00, u_byte} : rdata_q;
    // Pause while the data port waits, or while a fetch sits behind data work.
    assign stall = (mem_req && !mem_done) ||
                   (if_req && !valid_q &&
                    (grant_mem || u_busy || (state_q != IDLE && !fetch_q)));

endmodule
`default_nettype wire

// File: tb/tb_mem_sched.sv
`default_nettype none
// ============================================================================
// tb_mem_sched
// Directed bench for mem_sched: fetch, grant alternation, SRAM writes and
// reads, address boundary, UART read/write/status and mid-write reset.
// Revision: 1.0
// ============================================================================
module tb_mem_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_pc = 16'h0;
    logic [15:0] if_inst;
    logic        if_valid;
    logic        mem_req = 1'b0;
    logic        mem_op = 1'b0;
    logic [17:0] mem_addr = 18'h0;
    logic [15:0] mem_wdata = 16'h0;
    logic [15:0] mem_rdata;
    logic        mem_done, stall;
    logic [17:0] s2_addr, r1_addr;
    logic [15:0] s2_wdata, r1_wdata;
    logic [15:0] s2_rdata = 16'h0;
    logic [15:0] r1_rdata = 16'h0;
    logic        s2_drive, s2_ce_n, s2_oe_n, s2_we_n;
    logic        r1_drive, r1_ce_n, r1_oe_n, r1_we_n;
    logic        rdn, wrn;
    logic        data_ready = 1'b0;
    logic        tbre = 1'b1;
    logic        tsre = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    mem_sched dut (
        .clk_50MHz(clk), .rst(rst),
        .if_req(if_req), .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid),
        .mem_req(mem_req), .mem_op(mem_op), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .stall(stall),
        .s2_addr(s2_addr), .s2_wdata(s2_wdata), .s2_rdata(s2_rdata),
        .s2_drive(s2_drive), .s2_ce_n(s2_ce_n), .s2_oe_n(s2_oe_n), .s2_we_n(s2_we_n),
        .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_rdata(r1_rdata),
        .r1_drive(r1_drive), .r1_ce_n(r1_ce_n), .r1_oe_n(r1_oe_n), .r1_we_n(r1_we_n),
        .rdn(rdn), .wrn(wrn), .data_ready(data_ready), .tbre(tbre), .tsre(tsre)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bus-exclusion invariants sampled every cycle while out of reset.
    always @(negedge clk) begin
        if (rst) begin
            check("one_ce_low", {31'b0, (!s2_ce_n && !r1_ce_n)}, 32'd0);
            check("one_uart_strobe", {31'b0, (!rdn && !wrn)}, 32'd0);
        end
    end

    // Data-port read with hand-computed selects and result.
    task automatic do_read(input string tag, input logic [17:0] a,
                           input logic exp_s2, input logic [15:0] exp_d);
        mem_req = 1'b1; mem_op = 1'b0; mem_addr = a;
        @(negedge clk);
        check({tag, "_s2ce"}, {31'b0, s2_ce_n}, {31'b0, !exp_s2});
        check({tag, "_r1ce"}, {31'b0, r1_ce_n}, {31'b0, exp_s2});
        @(negedge clk);
        check({tag, "_done"}, {31'b0, mem_done}, 32'd1);
        check({tag, "_rdata"}, {16'b0, mem_rdata}, {16'b0, exp_d});
        mem_req = 1'b0;
    endtask

    initial begin
        int we_cnt, drv_cnt, stall_cnt, done_at, nev, rdn_hi, early;
        logic [3:0] order;

        // Reset values, asynchronously applied.
        #1;
        check("rst_s2_ce_n", {31'b0, s2_ce_n}, 32'd1);
        check("rst_s2_we_n", {31'b0, s2_we_n}, 32'd1);
        check("rst_r1_ce_n", {31'b0, r1_ce_n}, 32'd1);
        check("rst_uart", {30'b0, rdn, wrn}, 32'd3);
        check("rst_acks", {30'b0, if_valid, mem_done}, 32'd0);
        check("rst_drive", {30'b0, s2_drive, r1_drive}, 32'd0);
        check("rst_addr", {14'b0, s2_addr}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Fetch from SRAM2.
        if_req = 1'b1; if_pc = 16'h0040; s2_rdata = 16'h4F01;
        @(negedge clk);
        check("fetch_addr", {14'b0, s2_addr}, 32'h00040);
        check("fetch_oe", {30'b0, s2_ce_n, s2_oe_n}, 32'd0);
        check("fetch_valid_early", {31'b0, if_valid}, 32'd0);
        @(negedge clk);
        check("fetch_valid", {31'b0, if_valid}, 32'd1);
        check("fetch_inst", {16'b0, if_inst}, 32'h4F01);
        check("fetch_addr_released", {31'b0, s2_ce_n}, 32'd1);
        if_req = 1'b0;
        @(negedge clk);
        check("fetch_valid_pulse", {31'b0, if_valid}, 32'd0);

        // Both ports held: grants must alternate starting with data port.
        if_req = 1'b1; mem_req = 1'b1; mem_op = 1'b0; mem_addr = 18'h00200;
        s2_rdata = 16'h1111;
        nev = 0; order = 4'b0;
        for (int c = 0; c < 40 && nev < 4; c++) begin
            @(negedge clk);
            if (mem_done || if_valid) begin
                order[nev] = mem_done;
                nev++;
            end
        end
        if_req = 1'b0; mem_req = 1'b0;
        check("alt_events", nev, 32'd4);
        check("alt_order", {28'b0, order}, 32'b0101);
        @(negedge clk);

        // SRAM2 write: one we_n cycle, two drive cycles, stall until done.
        mem_req = 1'b1; mem_op = 1'b1; mem_addr = 18'h00123; mem_wdata = 16'hBEEF;
        we_cnt = 0; drv_cnt = 0; stall_cnt = 0; done_at = -1;
        for (int c = 1; c <= 10 && done_at < 0; c++) begin
            @(negedge clk);
            if (!s2_we_n) we_cnt++;
            if (s2_drive) begin
                drv_cnt++;
                check("wr_data", {16'b0, s2_wdata}, 32'hBEEF);
                check("wr_addr", {14'b0, s2_addr}, 32'h00123);
            end
            if (mem_done) begin
                done_at = c;
                check("wr_stall_at_done", {31'b0, stall}, 32'd0);
            end else if (stall) stall_cnt++;
        end
        mem_req = 1'b0;
        check("wr_we_cycles", we_cnt, 32'd1);
        check("wr_drive_cycles", drv_cnt, 32'd2);
        check("wr_done_cycle", done_at, 32'd3);
        check("wr_stall_cycles", stall_cnt, 32'd2);
        @(negedge clk);

        // Address-map boundaries.
        s2_rdata = 16'hABCD; r1_rdata = 16'h1234;
        do_read("rd_ram2_top", 18'h07FFF, 1'b1, 16'hABCD);
        @(negedge clk);
        do_read("rd_ram1_low", 18'h08000, 1'b0, 16'h1234);
        @(negedge clk);

        // UART read: rdn held high while data_ready is low.
        r1_rdata = 16'hA55A; data_ready = 1'b0;
        mem_req = 1'b1; mem_op = 1'b0; mem_addr = 18'h0BF00;
        rdn_hi = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rdn) rdn_hi++;
        end
        check("urd_rdn_wait", rdn_hi, 32'd5);
        data_ready = 1'b1;
        @(negedge clk);
        check("urd_rdn_low", {31'b0, rdn}, 32'd0);
        @(negedge clk);
        check("urd_done", {31'b0, mem_done}, 32'd1);
        check("urd_rdata", {16'b0, mem_rdata}, 32'h005A);
        check("urd_rdn_high", {31'b0, rdn}, 32'd1);
        mem_req = 1'b0; data_ready = 1'b0;
        @(negedge clk);

        // UART write: done held back until the transmitter drains.
        tsre = 1'b0;
        mem_req = 1'b1; mem_op = 1'b1; mem_addr = 18'h0BF00; mem_wdata = 16'h00C3;
        @(negedge clk);
        check("uwr_wrn_low", {31'b0, wrn}, 32'd0);
        check("uwr_drive", {31'b0, r1_drive}, 32'd1);
        check("uwr_data", {16'b0, r1_wdata}, 32'h00C3);
        early = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_done) early++;
        end
        check("uwr_wrn_high", {31'b0, wrn}, 32'd1);
        check("uwr_no_early_done", early, 32'd0);
        tsre = 1'b1;
        done_at = -1;
        for (int c = 1; c <= 10 && done_at < 0; c++) begin
            @(negedge clk);
            if (mem_done) done_at = c;
        end
        check("uwr_done_after_tsre", done_at, 32'd1);
        mem_req = 1'b0;
        @(negedge clk);

        // Status read with all flags high, then an ignored status write.
        data_ready = 1'b1; tbre = 1'b1; tsre = 1'b1;
        mem_req = 1'b1; mem_op = 1'b0; mem_addr = 18'h0BF01;
        @(negedge clk);
        check("stat_done", {31'b0, mem_done}, 32'd1);
        check("stat_rdata", {16'b0, mem_rdata}, 32'h0003);
        check("stat_no_strobe", {29'b0, rdn, wrn, r1_ce_n}, 32'd7);
        mem_req = 1'b0;
        @(negedge clk);
        data_ready = 1'b0;
        mem_req = 1'b1; mem_op = 1'b1; mem_addr = 18'h0BF01; mem_wdata = 16'hFFFF;
        @(negedge clk);
        check("statw_done", {31'b0, mem_done}, 32'd1);
        check("statw_rdata_kept", {16'b0, mem_rdata}, 32'h0003);
        mem_req = 1'b0;
        @(negedge clk);

        // Reset during S_WR1 clears strobes without a clock edge.
        mem_req = 1'b1; mem_op = 1'b1; mem_addr = 18'h00010; mem_wdata = 16'h5555;
        @(negedge clk);
        check("rstw_we_low", {31'b0, s2_we_n}, 32'd0);
        #2 rst = 1'b0;
        #1;
        check("rstw_we_n", {31'b0, s2_we_n}, 32'd1);
        check("rstw_drive", {31'b0, s2_drive}, 32'd0);
        check("rstw_ce_addr", {13'b0, s2_ce_n, s2_addr}, {13'b0, 1'b1, 18'h0});
        mem_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        early = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_done || !s2_ce_n) early++;
        end
        check("rstw_idle_after", early, 32'd0);
        if_req = 1'b1; if_pc = 16'h0007; s2_rdata = 16'h7777;
        @(negedge clk);
        check("rstw_first_grant", {13'b0, s2_ce_n, s2_addr}, {13'b0, 1'b0, 18'h00007});
        @(negedge clk);
        check("rstw_fetch_inst", {15'b0, if_valid, if_inst}, {15'b0, 1'b1, 16'h7777});
        if_req = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
